// File: rtl/time_frame_capture_pkg.sv
// Shared constants and state encoding for the time-domain frame capture block.
package time_frame_capture_pkg;

    localparam int unsigned ADDR_W    = 10;
    localparam int unsigned FRAME_LEN = 1 << ADDR_W;

    localparam int SAMPLE_MAX = 127;
    localparam int SAMPLE_MIN = -128;

    typedef enum logic [1:0] {
        StIdle,
        StArm,
        StCapture,
        StDone
    } state_e;

endpackage

// File: rtl/sample_scaler.sv
// Gain-dependent arithmetic right shift of a 16-bit PCM sample, saturated to 8 bits.
module sample_scaler
    import time_frame_capture_pkg::*;
(
    input  logic [15:0] sample,
    input  logic [2:0]  gain_sel,
    output logic [7:0]  scaled
);

    logic [3:0]         shift;
    logic signed [15:0] shifted;

    always_comb begin
        shift   = 4'd8 - {1'b0, gain_sel};
        shifted = $signed(sample) >>> shift;
        if (int'(shifted) > SAMPLE_MAX) begin
            scaled = 8'(SAMPLE_MAX);
        end else if (int'(shifted) < SAMPLE_MIN) begin
            scaled = 8'(SAMPLE_MIN);
        end else begin
            scaled = shifted[7:0];
        end
    end

endmodule

// File: rtl/time_frame_capture.sv
// Captures one frame of scaled microphone samples into the time buffer per start request.
// Optional per-frame absolute peak tracking is enabled with macro TIME_FRAME_PEAK_EN.
module time_frame_capture #(
    parameter int unsigned FRAME_LEN = 1024,
    parameter int unsigned ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              sample_valid_i,
    input  logic [15:0]       sample_i,
    input  logic [2:0]        gain_sel_i,
    output logic              frame_active_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [7:0]        din_o,
    output logic              frame_done_o,
    output logic              overrun_o,
    output logic [7:0]        peak_o
);

    import time_frame_capture_pkg::*;

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(FRAME_LEN - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [2:0]        gain_q, gain_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        din_q, din_d;
    logic              overrun_q, overrun_d;
    logic              we_q;
    logic              wr;
    logic [7:0]        scaled;

    // Gain is latched per frame so switch changes mid-frame have no effect.
    sample_scaler u_scaler (
        .sample   (sample_i),
        .gain_sel (gain_q),
        .scaled   (scaled)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        gain_d    = gain_q;
        addr_d    = addr_q;
        din_d     = din_q;
        overrun_d = overrun_q;
        wr        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StArm;
                    gain_d  = gain_sel_i;
                    idx_d   = '0;
                end
            end
            StArm, StCapture: begin
                if (start_i) overrun_d = 1'b1;
                if (sample_valid_i) begin
                    wr     = 1'b1;
                    addr_d = idx_q;
                    din_d  = scaled;
                    if (idx_q == LastIdx) begin
                        idx_d   = '0;
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + ADDR_W'(1);
                        state_d = StCapture;
                    end
                end
            end
            StDone: begin
                if (start_i) overrun_d = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            gain_q    <= '0;
            addr_q    <= '0;
            din_q     <= '0;
            overrun_q <= 1'b0;
            we_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            gain_q    <= gain_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            overrun_q <= overrun_d;
            we_q      <= wr;
        end
    end

    assign frame_active_o = (state_q != StIdle);
    assign frame_done_o   = (state_q == StDone);
    assign we_o           = we_q;
    assign addr_o         = addr_q;
    assign din_o          = din_q;
    assign overrun_o      = overrun_q;

`ifdef TIME_FRAME_PEAK_EN
    logic [7:0] abs_scaled;
    logic [7:0] run_max_q;
    logic [7:0] peak_q;
    logic       arm;

    // |-128| does not fit in 7 bits of magnitude, so it clamps to 127.
    always_comb begin
        if (scaled[7]) begin
            abs_scaled = (scaled == 8'h80) ? 8'h7f : (~scaled + 8'd1);
        end else begin
            abs_scaled = scaled;
        end
    end

    assign arm = (state_q == StIdle) && start_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            run_max_q <= '0;
            peak_q    <= '0;
        end else begin
            if (arm) begin
                run_max_q <= '0;
            end else if (wr && (abs_scaled > run_max_q)) begin
                run_max_q <= abs_scaled;
            end
            if (state_q == StDone) peak_q <= run_max_q;
        end
    end

    assign peak_o = peak_q;
`else
    assign peak_o = '0;
`endif

endmodule

// File: tb/tb_time_frame_capture.sv
// Scoreboard bench for time_frame_capture: a cycle model pushes expected writes, a monitor pops them.
module tb_time_frame_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic        sample_valid_i;
    logic [15:0] sample_i;
    logic [2:0]  gain_sel_i;
    logic        frame_active_o;
    logic        we_o;
    logic [9:0]  addr_o;
    logic [7:0]  din_o;
    logic        frame_done_o;
    logic        overrun_o;
    logic [7:0]  peak_o;

    always #5 clk = ~clk;

    time_frame_capture #(
        .FRAME_LEN (1024),
        .ADDR_W    (10)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start_i        (start_i),
        .sample_valid_i (sample_valid_i),
        .sample_i       (sample_i),
        .gain_sel_i     (gain_sel_i),
        .frame_active_o (frame_active_o),
        .we_o           (we_o),
        .addr_o         (addr_o),
        .din_o          (din_o),
        .frame_done_o   (frame_done_o),
        .overrun_o      (overrun_o),
        .peak_o         (peak_o)
    );

    typedef struct packed {
        logic [9:0] addr;
        logic [7:0] din;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;

    // Model state, valid for the cycle after the next active edge.
    int         m_state  = 0;  // 0 idle, 1 arm, 2 capture, 3 done
    int         m_idx    = 0;
    logic [2:0] m_gain   = '0;
    int         m_ovr    = 0;
    int         m_run    = 0;
    int         m_peak   = 0;
    int         m_addr   = 0;
    int         m_din    = 0;
    int         m_writes = 0;
    int         frames_seen = 0;
    bit         mon_en = 1'b0;

    task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_scale(input logic [15:0] s, input logic [2:0] g);
        int v;
        v = int'($signed(s));
        v = v >>> (8 - int'(g));
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return 8'(v);
    endfunction

    function automatic int ref_abs(input logic [7:0] d);
        int v;
        v = int'($signed(d));
        if (v < 0) v = -v;
        return (v > 127) ? 127 : v;
    endfunction

    task automatic step(input bit rst, input bit st, input bit vld,
                        input logic [15:0] s, input logic [2:0] g);
        logic [7:0] d;
        @(negedge clk);
        reset          = rst;
        start_i        = st;
        sample_valid_i = vld;
        sample_i       = s;
        gain_sel_i     = g;
        if (rst) begin
            m_state = 0; m_idx = 0; m_ovr = 0; m_run = 0;
            m_peak  = 0; m_addr = 0; m_din = 0;
        end else begin
            case (m_state)
                0: if (st) begin
                    m_state = 1; m_gain = g; m_run = 0; m_idx = 0;
                end
                1, 2: begin
                    if (st) m_ovr = 1;
                    if (vld) begin
                        d      = ref_scale(s, m_gain);
                        m_addr = m_idx;
                        m_din  = int'(d);
                        exp_q.push_back('{addr: 10'(m_idx), din: d});
                        m_writes++;
                        if (ref_abs(d) > m_run) m_run = ref_abs(d);
                        if (m_idx == 1023) begin
                            m_idx = 0; m_state = 3;
                        end else begin
                            m_idx++; m_state = 2;
                        end
                    end
                end
                default: begin
                    if (st) m_ovr = 1;
`ifdef TIME_FRAME_PEAK_EN
                    m_peak = m_run;
`endif
                    m_state = 0;
                end
            endcase
        end
    endtask

    always begin
        wr_t e;
        bit  exp_we;
        @(posedge clk);
        #1;
        if (mon_en) begin
            exp_we = (exp_q.size() != 0);
            check_val("we", 32'(we_o), 32'(exp_we));
            if (exp_we) begin
                e = exp_q.pop_front();
                check_val("wr_addr", 32'(addr_o), 32'(e.addr));
                check_val("wr_din", 32'(din_o), 32'(e.din));
            end else begin
                check_val("hold_addr", 32'(addr_o), 32'(m_addr));
                check_val("hold_din", 32'(din_o), 32'(m_din & 8'hff));
            end
            check_val("frame_active", 32'(frame_active_o), 32'(m_state != 0));
            check_val("frame_done", 32'(frame_done_o), 32'(m_state == 3));
            check_val("overrun", 32'(overrun_o), 32'(m_ovr));
            check_val("peak", 32'(peak_o), 32'(m_peak));
            if (frame_done_o) frames_seen++;
        end
    end

    // mode 0: constant 0x0100, 1: alternating full scale, 2: random.
    task automatic capture(input logic [2:0] g, input int mode, input int n_writes,
                           input int start_at, input int gchange_at, input bit coincident);
        int          target;
        bit          vld;
        bit          st;
        logic [15:0] s;
        logic [2:0]  g_now;
        target = m_writes + n_writes;
        step(1'b0, 1'b1, coincident, 16'h1234, g);
        while (m_writes < target) begin
            vld = ($urandom_range(0, 3) != 0);
            case (mode)
                0:       s = 16'h0100;
                1:       s = m_writes[0] ? 16'h8000 : 16'h7fff;
                default: s = 16'($urandom);
            endcase
            st    = vld && (start_at >= 0) && (m_writes == target - n_writes + start_at);
            g_now = ((gchange_at >= 0) && (m_writes >= target - n_writes + gchange_at)) ?
                    3'd0 : g;
            step(1'b0, st, vld, s, g_now);
        end
    endtask

    task automatic idle_strobes(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 16'(i * 77), 3'd4);
    endtask

    initial begin
        reset          = 1'b1;
        start_i        = 1'b0;
        sample_valid_i = 1'b0;
        sample_i       = '0;
        gain_sel_i     = '0;
        mon_en         = 1'b1;
        step(1'b1, 1'b0, 1'b0, 16'h0, 3'd0);
        step(1'b1, 1'b0, 1'b1, 16'h7fff, 3'd7);
        step(1'b0, 1'b0, 1'b0, 16'h0, 3'd0);
        check_val("reset_frames", 32'(frames_seen), 0);

        // Strobes in IDLE are ignored.
        idle_strobes(4);

        // Constant 0x0100 at gain 5 -> 0x20 everywhere, DONE-cycle strobe ignored.
        capture(3'd5, 0, 1024, -1, -1, 1'b0);
        idle_strobes(3);
        check_val("f1_frames", 32'(frames_seen), 1);
        check_val("f1_overrun", 32'(overrun_o), 0);
`ifdef TIME_FRAME_PEAK_EN
        check_val("f1_peak", 32'(peak_o), 32);
`else
        check_val("f1_peak", 32'(peak_o), 0);
`endif

        // Full-scale samples saturate to +127 / -128.
        capture(3'd7, 1, 1024, -1, -1, 1'b0);
        idle_strobes(3);
        check_val("f2_frames", 32'(frames_seen), 2);
`ifdef TIME_FRAME_PEAK_EN
        check_val("f2_peak", 32'(peak_o), 127);
`else
        check_val("f2_peak", 32'(peak_o), 0);
`endif

        // Start pulse at write 500 is dropped and flags overrun.
        capture(3'd5, 2, 1024, 500, -1, 1'b0);
        idle_strobes(3);
        check_val("f3_frames", 32'(frames_seen), 3);
        check_val("f3_overrun", 32'(overrun_o), 1);

        // Reset at write 300 abandons the frame.
        capture(3'd6, 2, 300, -1, -1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 16'h0, 3'd0);
        step(1'b1, 1'b0, 1'b1, 16'h4000, 3'd0);
        step(1'b0, 1'b0, 1'b0, 16'h0, 3'd0);
        check_val("abort_frames", 32'(frames_seen), 3);
        check_val("abort_overrun", 32'(overrun_o), 0);
        check_val("abort_active", 32'(frame_active_o), 0);

        // Start coincident with a strobe: that sample is not written.
        capture(3'd3, 2, 1024, -1, -1, 1'b1);
        idle_strobes(3);
        check_val("f4_frames", 32'(frames_seen), 4);

        // Gain switched 5 -> 0 mid-frame; the latched gain 5 still applies.
        capture(3'd5, 2, 1024, -1, 512, 1'b0);
        idle_strobes(3);
        check_val("f5_frames", 32'(frames_seen), 5);
        check_val("queue_empty", 32'(exp_q.size()), 0);

        @(negedge clk);
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
